spinnaker_fpgas_reg_arbiter: RTL and testbench

- Two-port arbiter that shares the top-level control/diagnostic register bank between two masters.
- Requester 0 is the host/SPI register interface; requester 1 is the on-chip diagnostic master.
- Grants one requester at a time, round-robin, and drives the bank's single write/addr/data interface.
- Captures the bank's combinational read data and returns it with a one-cycle acknowledge.

---
 rtl/spinnaker_fpgas_reg_arbiter.sv | 112 +++++++++++
 tb/tb_spinnaker_fpgas_reg_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spinnaker_fpgas_reg_arbiter.sv
// Round-robin arbiter sharing the control/diagnostic register bank between
// the host register interface (requester 0) and the diagnostic master (requester 1).
module spinnaker_fpgas_reg_arbiter #(
  parameter int REGA_BITS = 14,
  parameter int REGD_BITS = 32
) (
  input  logic                 CLK_IN,
  input  logic                 RESET_IN,

  input  logic                 REQ0_IN,
  input  logic                 WRITE0_IN,
  input  logic [REGA_BITS-1:0] ADDR0_IN,
  input  logic [REGD_BITS-1:0] WDATA0_IN,
  output logic                 ACK0_OUT,
  output logic [REGD_BITS-1:0] RDATA0_OUT,

  input  logic                 REQ1_IN,
  input  logic                 WRITE1_IN,
  input  logic [REGA_BITS-1:0] ADDR1_IN,
  input  logic [REGD_BITS-1:0] WDATA1_IN,
  output logic                 ACK1_OUT,
  output logic [REGD_BITS-1:0] RDATA1_OUT,

  output logic                 REG_WRITE_OUT,
  output logic [REGA_BITS-1:0] REG_ADDR_OUT,
  output logic [REGD_BITS-1:0] REG_WDATA_OUT,
  input  logic [REGD_BITS-1:0] REG_RDATA_IN
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACKN   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic last_grant;
  logic grant;
  logic do_grant;
  logic grant_sel;

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) state <= IDLE;
    else          state <= state_nxt;
  end

  // On contention the requester that was not served last wins.
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    grant_sel = 1'b0;
    case (state)
      IDLE: begin
        if (REQ0_IN || REQ1_IN) begin
          do_grant  = 1'b1;
          state_nxt = ACCESS;
          if (REQ0_IN && REQ1_IN) grant_sel = ~last_grant;
          else                    grant_sel = REQ1_IN;
        end
      end
      ACCESS:  state_nxt = ACKN;
      ACKN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The write strobe is a reset flop, so reset during ACCESS removes it at
  // once and the bank never sees a closing edge with the strobe high.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      last_grant    <= 1'b1;
      grant         <= 1'b0;
      REG_WRITE_OUT <= 1'b0;
      REG_ADDR_OUT  <= '0;
      REG_WDATA_OUT <= '0;
      ACK0_OUT      <= 1'b0;
      ACK1_OUT      <= 1'b0;
      RDATA0_OUT    <= '0;
      RDATA1_OUT    <= '0;
    end else begin
      REG_WRITE_OUT <= 1'b0;
      ACK0_OUT      <= 1'b0;
      ACK1_OUT      <= 1'b0;

      if (do_grant) begin
        grant      <= grant_sel;
        last_grant <= grant_sel;
        if (grant_sel) begin
          REG_WRITE_OUT <= WRITE1_IN;
          REG_ADDR_OUT  <= ADDR1_IN;
          REG_WDATA_OUT <= WDATA1_IN;
        end else begin
          REG_WRITE_OUT <= WRITE0_IN;
          REG_ADDR_OUT  <= ADDR0_IN;
          REG_WDATA_OUT <= WDATA0_IN;
        end
      end

      if (state == ACCESS) begin
        if (grant) begin
          RDATA1_OUT <= REG_RDATA_IN;
          ACK1_OUT   <= 1'b1;
        end else begin
          RDATA0_OUT <= REG_RDATA_IN;
          ACK0_OUT   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spinnaker_fpgas_reg_arbiter.sv
// Directed bench for the register-bank arbiter with a small behavioural bank
// (VERSION, scratch, key, mask; unmapped addresses read all-ones).
`timescale 1ns/1ps
module tb_spinnaker_fpgas_reg_arbiter;

  localparam int REGA_BITS = 14;
  localparam int REGD_BITS = 32;
  localparam logic [31:0] VERSION_IN = 32'h0001_0203;

  logic                 clk = 1'b0;
  logic                 RESET_IN;
  logic                 bank_rst;
  logic                 REQ0_IN, WRITE0_IN, REQ1_IN, WRITE1_IN;
  logic [REGA_BITS-1:0] ADDR0_IN, ADDR1_IN;
  logic [REGD_BITS-1:0] WDATA0_IN, WDATA1_IN;
  logic                 ACK0_OUT, ACK1_OUT;
  logic [REGD_BITS-1:0] RDATA0_OUT, RDATA1_OUT;
  logic                 REG_WRITE_OUT;
  logic [REGA_BITS-1:0] REG_ADDR_OUT;
  logic [REGD_BITS-1:0] REG_WDATA_OUT;
  logic [REGD_BITS-1:0] REG_RDATA_IN;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spinnaker_fpgas_reg_arbiter #(.REGA_BITS(REGA_BITS), .REGD_BITS(REGD_BITS)) dut (
    .CLK_IN(clk), .RESET_IN(RESET_IN),
    .REQ0_IN(REQ0_IN), .WRITE0_IN(WRITE0_IN), .ADDR0_IN(ADDR0_IN), .WDATA0_IN(WDATA0_IN),
    .ACK0_OUT(ACK0_OUT), .RDATA0_OUT(RDATA0_OUT),
    .REQ1_IN(REQ1_IN), .WRITE1_IN(WRITE1_IN), .ADDR1_IN(ADDR1_IN), .WDATA1_IN(WDATA1_IN),
    .ACK1_OUT(ACK1_OUT), .RDATA1_OUT(RDATA1_OUT),
    .REG_WRITE_OUT(REG_WRITE_OUT), .REG_ADDR_OUT(REG_ADDR_OUT),
    .REG_WDATA_OUT(REG_WDATA_OUT), .REG_RDATA_IN(REG_RDATA_IN)
  );

  // Bank has its own reset so an aborted write is visible as a missing update.
  logic [31:0] r_scratch, r_key, r_mask;
  always_ff @(posedge clk or posedge bank_rst) begin
    if (bank_rst) begin
      r_scratch <= 32'h0000_00A5;
      r_key     <= 32'hFFFF_FFFF;
      r_mask    <= 32'h0000_0000;
    end else if (REG_WRITE_OUT) begin
      case (REG_ADDR_OUT)
        14'd1:   r_scratch <= REG_WDATA_OUT;
        14'd2:   r_key     <= REG_WDATA_OUT;
        14'd3:   r_mask    <= REG_WDATA_OUT;
        default: ;
      endcase
    end
  end

  always_comb begin
    REG_RDATA_IN = 32'hFFFF_FFFF;
    case (REG_ADDR_OUT)
      14'd0:   REG_RDATA_IN = VERSION_IN;
      14'd1:   REG_RDATA_IN = r_scratch;
      14'd2:   REG_RDATA_IN = r_key;
      14'd3:   REG_RDATA_IN = r_mask;
      default: REG_RDATA_IN = 32'hFFFF_FFFF;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    RESET_IN = 1'b1; bank_rst = 1'b1;
    REQ0_IN = 0; WRITE0_IN = 0; ADDR0_IN = '0; WDATA0_IN = '0;
    REQ1_IN = 0; WRITE1_IN = 0; ADDR1_IN = '0; WDATA1_IN = '0;
    tick; tick;
    n_cmp++; if ({ACK0_OUT, ACK1_OUT, REG_WRITE_OUT} !== 3'b000) begin
      n_bad++; $display("FAIL reset_strobes: got %b want 000", {ACK0_OUT, ACK1_OUT, REG_WRITE_OUT}); end
    n_cmp++; if (RDATA0_OUT !== 32'h0 || RDATA1_OUT !== 32'h0) begin
      n_bad++; $display("FAIL reset_rdata: got %h/%h want 0/0", RDATA0_OUT, RDATA1_OUT); end
    n_cmp++; if (REG_ADDR_OUT !== 14'h0 || REG_WDATA_OUT !== 32'h0) begin
      n_bad++; $display("FAIL reset_bank_if: got %h/%h want 0/0", REG_ADDR_OUT, REG_WDATA_OUT); end
    RESET_IN = 1'b0; bank_rst = 1'b0;
    tick;
  endtask

  task automatic test_read_version;
    REQ0_IN = 1; WRITE0_IN = 0; ADDR0_IN = 14'd0;
    tick;
    n_cmp++; if (ACK0_OUT !== 1'b0 || REG_WRITE_OUT !== 1'b0) begin
      n_bad++; $display("FAIL ver_access: ack0=%b wr=%b want 0 0", ACK0_OUT, REG_WRITE_OUT); end
    tick;
    n_cmp++; if (ACK0_OUT !== 1'b1 || ACK1_OUT !== 1'b0) begin
      n_bad++; $display("FAIL ver_ack: ack0=%b ack1=%b want 1 0", ACK0_OUT, ACK1_OUT); end
    n_cmp++; if (RDATA0_OUT !== 32'h0001_0203) begin
      n_bad++; $display("FAIL ver_rdata: got %h want 00010203", RDATA0_OUT); end
    REQ0_IN = 0;
    tick;
    n_cmp++; if (ACK0_OUT !== 1'b0) begin
      n_bad++; $display("FAIL ver_ack_pulse: ack0=%b want 0", ACK0_OUT); end
  endtask

  task automatic test_write_key;
    REQ1_IN = 1; WRITE1_IN = 1; ADDR1_IN = 14'd2; WDATA1_IN = 32'hDEAD_0000;
    n_cmp++; if (REG_WRITE_OUT !== 1'b0) begin
      n_bad++; $display("FAIL wr_pre: wr=%b want 0", REG_WRITE_OUT); end
    tick;
    n_cmp++; if (REG_WRITE_OUT !== 1'b1 || REG_ADDR_OUT !== 14'd2 || REG_WDATA_OUT !== 32'hDEAD_0000) begin
      n_bad++; $display("FAIL wr_access: wr=%b addr=%h wdata=%h want 1 0002 dead0000",
                        REG_WRITE_OUT, REG_ADDR_OUT, REG_WDATA_OUT); end
    ADDR1_IN = 14'd7; WDATA1_IN = 32'h5555_5555;
    tick;
    n_cmp++; if (REG_WRITE_OUT !== 1'b0 || ACK1_OUT !== 1'b1 || ACK0_OUT !== 1'b0) begin
      n_bad++; $display("FAIL wr_ack: wr=%b ack1=%b ack0=%b want 0 1 0", REG_WRITE_OUT, ACK1_OUT, ACK0_OUT); end
    n_cmp++; if (RDATA1_OUT !== 32'hFFFF_FFFF || RDATA0_OUT !== 32'h0001_0203) begin
      n_bad++; $display("FAIL wr_rdata: got %h/%h want ffffffff/00010203", RDATA1_OUT, RDATA0_OUT); end
    REQ1_IN = 0; WRITE1_IN = 0;
    tick;
    n_cmp++; if (ACK1_OUT !== 1'b0 || REG_ADDR_OUT !== 14'd2 || REG_WDATA_OUT !== 32'hDEAD_0000) begin
      n_bad++; $display("FAIL wr_hold: ack1=%b addr=%h wdata=%h want 0 0002 dead0000",
                        ACK1_OUT, REG_ADDR_OUT, REG_WDATA_OUT); end
    REQ0_IN = 1; WRITE0_IN = 0; ADDR0_IN = 14'd2;
    tick; tick;
    n_cmp++; if (ACK0_OUT !== 1'b1 || RDATA0_OUT !== 32'hDEAD_0000 || RDATA1_OUT !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL key_readback: ack0=%b r0=%h r1=%h want 1 dead0000 ffffffff",
                        ACK0_OUT, RDATA0_OUT, RDATA1_OUT); end
    REQ0_IN = 0;
    tick;
  endtask

  task automatic test_simultaneous;
    RESET_IN = 1; tick; RESET_IN = 0;
    REQ0_IN = 1; WRITE0_IN = 0; ADDR0_IN = 14'd1;
    REQ1_IN = 1; WRITE1_IN = 0; ADDR1_IN = 14'd3;
    for (int i = 1; i <= 5; i++) begin
      tick;
      n_cmp++; if (ACK0_OUT !== (i == 2) || ACK1_OUT !== (i == 5)) begin
        n_bad++; $display("FAIL simul_ack[%0d]: ack0=%b ack1=%b want %b %b", i, ACK0_OUT, ACK1_OUT,
                          (i == 2), (i == 5)); end
      if (i == 2) begin
        n_cmp++; if (RDATA0_OUT !== 32'h0000_00A5) begin
          n_bad++; $display("FAIL simul_r0: got %h want 000000a5", RDATA0_OUT); end
        REQ0_IN = 0;
      end
      if (i == 5) begin
        n_cmp++; if (RDATA1_OUT !== 32'h0000_0000 || RDATA0_OUT !== 32'h0000_00A5) begin
          n_bad++; $display("FAIL simul_r1: got %h/%h want 00000000/000000a5", RDATA1_OUT, RDATA0_OUT); end
        REQ1_IN = 0;
      end
    end
    tick;
  endtask

  task automatic test_back_to_back;
    REQ0_IN = 1; WRITE0_IN = 0; ADDR0_IN = 14'd0;
    REQ1_IN = 1; WRITE1_IN = 0; ADDR1_IN = 14'd5;
    for (int i = 1; i <= 12; i++) begin
      tick;
      n_cmp++; if (ACK0_OUT !== (i == 2 || i == 8) || ACK1_OUT !== (i == 5 || i == 11)) begin
        n_bad++; $display("FAIL b2b_ack[%0d]: ack0=%b ack1=%b want %b %b", i, ACK0_OUT, ACK1_OUT,
                          (i == 2 || i == 8), (i == 5 || i == 11)); end
      if (i == 5) begin
        n_cmp++; if (RDATA0_OUT !== 32'h0001_0203 || RDATA1_OUT !== 32'hFFFF_FFFF) begin
          n_bad++; $display("FAIL b2b_rdata: got %h/%h want 00010203/ffffffff", RDATA0_OUT, RDATA1_OUT); end
      end
    end
    REQ0_IN = 0; REQ1_IN = 0;
    tick; tick; tick;
    n_cmp++; if (ACK0_OUT !== 1'b0 || ACK1_OUT !== 1'b0) begin
      n_bad++; $display("FAIL b2b_idle: ack0=%b ack1=%b want 0 0", ACK0_OUT, ACK1_OUT); end
  endtask

  task automatic test_unmapped;
    REQ0_IN = 1; WRITE0_IN = 0; ADDR0_IN = 14'd5;
    tick; tick;
    n_cmp++; if (ACK0_OUT !== 1'b1 || RDATA0_OUT !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL unmapped: ack0=%b r0=%h want 1 ffffffff", ACK0_OUT, RDATA0_OUT); end
    REQ0_IN = 0;
    tick;
  endtask

  task automatic test_reset_mid_write;
    REQ0_IN = 1; WRITE0_IN = 1; ADDR0_IN = 14'd3; WDATA0_IN = 32'h1234_5678;
    tick;
    n_cmp++; if (REG_WRITE_OUT !== 1'b1) begin
      n_bad++; $display("FAIL abort_access: wr=%b want 1", REG_WRITE_OUT); end
    RESET_IN = 1;
    #1;
    n_cmp++; if (REG_WRITE_OUT !== 1'b0) begin
      n_bad++; $display("FAIL abort_async: wr=%b want 0", REG_WRITE_OUT); end
    tick;
    RESET_IN = 0; REQ0_IN = 0; WRITE0_IN = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (ACK0_OUT !== 1'b0 || ACK1_OUT !== 1'b0) begin
        n_bad++; $display("FAIL abort_noack[%0d]: ack0=%b ack1=%b want 0 0", i, ACK0_OUT, ACK1_OUT); end
    end
    n_cmp++; if (RDATA0_OUT !== 32'h0) begin
      n_bad++; $display("FAIL abort_rdata_rst: got %h want 0", RDATA0_OUT); end
    REQ0_IN = 1; WRITE0_IN = 0; ADDR0_IN = 14'd3;
    tick; tick;
    n_cmp++; if (ACK0_OUT !== 1'b1 || RDATA0_OUT !== 32'h0000_0000) begin
      n_bad++; $display("FAIL abort_readback: ack0=%b r0=%h want 1 00000000", ACK0_OUT, RDATA0_OUT); end
    REQ0_IN = 0;
    tick;
  endtask

  initial begin
    test_reset;
    test_read_version;
    test_write_key;
    test_simultaneous;
    test_back_to_back;
    test_unmapped;
    test_reset_mid_write;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
